// File: rtl/bsk_pkg.sv
// -----------------------------------------------------------------------------
// bsk_pkg
// Shared constants and helpers for the BSK command-receiver (PRD) board.
//   COM_NUM          number of command lines on the PRD board
//   COM_DEFAULT      idle value of the command bus (commands are active 0)
//   COM_IND_DEFAULT  idle value of the indicator bus (indicators are active 1)
//   clog2()          counter width helper, never returns less than 1
// -----------------------------------------------------------------------------
package bsk_pkg;

  localparam int COM_NUM = 16;
  localparam logic [COM_NUM-1:0] COM_DEFAULT     = 16'hFFFF;
  localparam logic [COM_NUM-1:0] COM_IND_DEFAULT = 16'h0000;

  // Bits needed to hold 0..value-1; a 1-bit minimum keeps degenerate
  // counters (value 1 or 2) legal.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage : bsk_pkg

// File: rtl/bsk_com_filter_ch.sv
// -----------------------------------------------------------------------------
// bsk_com_filter_ch
// One command channel: two-flop synchroniser, consecutive-sample counter and
// filtered output flop.
//   iClk    system clock
//   iRes    asynchronous reset, active 0
//   tick    sample strobe from the shared prescaler (one clock wide)
//   raw     raw command bit, active 0, asynchronous to iClk
//   filt    filtered command bit, active 0, resets to 1
//   change  high on the tick cycle in which filt will take a new value;
//           derived from registers only, so raw has no combinational path out
// -----------------------------------------------------------------------------
module bsk_com_filter_ch
  import bsk_pkg::*;
#(
  parameter int FILT_LEN = 8
) (
  input  logic iClk,
  input  logic iRes,
  input  logic tick,
  input  logic raw,
  output logic filt,
  output logic change
);

  localparam int CNT_W = clog2(FILT_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             filt_reg;
  logic             filt_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             differ;

  // Synchroniser idles at 1 so a reset never looks like an active command.
  always_ff @(posedge iClk or negedge iRes) begin
    if (!iRes) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
    end
  end

  always_ff @(posedge iClk or negedge iRes) begin
    if (!iRes) begin
      filt_reg <= 1'b1;
      cnt_reg  <= '0;
    end else begin
      filt_reg <= filt_next;
      cnt_reg  <= cnt_next;
    end
  end

  // The counter tracks how many consecutive ticks have disagreed with the
  // current output. The accepting tick is the FILT_LEN-th disagreeing one,
  // so the counter tops out at FILT_LEN-1 and never wraps.
  always_comb begin
    filt_next = filt_reg;
    cnt_next  = cnt_reg;
    differ    = (sync2_reg != filt_reg);
    change    = 1'b0;
    if (tick) begin
      if (!differ) begin
        cnt_next = '0;
      end else if (cnt_reg == CNT_MAX) begin
        filt_next = sync2_reg;
        cnt_next  = '0;
        change    = 1'b1;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  assign filt = filt_reg;

endmodule : bsk_com_filter_ch

// File: rtl/bsk_com_filter.sv
// -----------------------------------------------------------------------------
// bsk_com_filter
// Input conditioner for the PRD command lines. Each raw, active-low command
// is synchronised, sampled on a prescaled tick, and only passed on after
// FILT_LEN consecutive samples at the new level.
//   iClk     system clock
//   iRes     asynchronous reset, active 0
//   iComRaw  raw command inputs, active 0, asynchronous to iClk
//   oCom     filtered commands, active 0 (feeds PRD iCom)
//   oChange  one-clock pulse in the clock where oCom holds new contents
//   oTick    registered sample tick, for debug
// -----------------------------------------------------------------------------
module bsk_com_filter
  import bsk_pkg::*;
#(
  parameter int CH_NUM   = COM_NUM,
  parameter int PRESC    = 50,
  parameter int FILT_LEN = 8
) (
  input  logic              iClk,
  input  logic              iRes,
  input  logic [CH_NUM-1:0] iComRaw,
  output logic [CH_NUM-1:0] oCom,
  output logic              oChange,
  output logic              oTick
);

  localparam logic [15:0] PSC_MAX = 16'(PRESC - 1);

  logic [15:0]       psc_reg;
  logic [15:0]       psc_next;
  logic              tick;
  logic              tick_reg;
  logic              change_reg;
  logic [CH_NUM-1:0] change_vec;

  // Prescaler: 0..PRESC-1; with PRESC=1 it sits at 0 and ticks every clock.
  always_comb begin
    tick     = (psc_reg == PSC_MAX);
    psc_next = tick ? 16'd0 : psc_reg + 16'd1;
  end

  always_ff @(posedge iClk or negedge iRes) begin
    if (!iRes) begin
      psc_reg    <= '0;
      tick_reg   <= 1'b0;
      change_reg <= 1'b0;
    end else begin
      psc_reg    <= psc_next;
      tick_reg   <= tick;
      // Registered alongside the channel output flops, so the pulse lines
      // up with the clock in which oCom shows the new value. Several
      // channels switching together merge into one pulse.
      change_reg <= |change_vec;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
      bsk_com_filter_ch #(
        .FILT_LEN (FILT_LEN)
      ) u_ch (
        .iClk   (iClk),
        .iRes   (iRes),
        .tick   (tick),
        .raw    (iComRaw[gi]),
        .filt   (oCom[gi]),
        .change (change_vec[gi])
      );
    end
  endgenerate

  assign oChange = change_reg;
  assign oTick   = tick_reg;

endmodule : bsk_com_filter

// File: tb/tb_bsk_com_filter.sv
// -----------------------------------------------------------------------------
// tb_bsk_com_filter
// Directed bench for bsk_com_filter with PRESC=4, FILT_LEN=3. Inputs change
// 1 time unit after a rising edge; outputs are sampled at the same point.
// Raw-edge to oCom-edge latency, counted in rising edges after the drive,
// is 11..14.
// -----------------------------------------------------------------------------
module tb_bsk_com_filter;

  localparam int PRESC    = 4;
  localparam int FILT_LEN = 3;
  localparam int LAT_MIN  = (FILT_LEN - 1) * PRESC + 3;
  localparam int LAT_MAX  = FILT_LEN * PRESC + 2;

  logic        iClk    = 1'b0;
  logic        iRes    = 1'b0;
  logic [15:0] iComRaw = 16'hFFFF;
  logic [15:0] oCom;
  logic        oChange;
  logic        oTick;

  int errors = 0;
  int checks = 0;

  bsk_com_filter #(
    .CH_NUM   (16),
    .PRESC    (PRESC),
    .FILT_LEN (FILT_LEN)
  ) dut (
    .iClk    (iClk),
    .iRes    (iRes),
    .iComRaw (iComRaw),
    .oCom    (oCom),
    .oChange (oChange),
    .oTick   (oTick)
  );

  always #5 iClk = ~iClk;

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  // Observe n clocks; report the first clock where oCom leaves base, what it
  // became, oChange on that clock, and the total number of oChange pulses.
  task automatic measure(input int n, input logic [15:0] base,
                         output int first, output logic [15:0] first_com,
                         output logic first_chg, output int pulses);
    first     = 0;
    first_com = base;
    first_chg = 1'b0;
    pulses    = 0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (oChange === 1'b1) pulses++;
      if (first == 0 && oCom !== base) begin
        first     = i;
        first_com = oCom;
        first_chg = oChange;
      end
    end
  endtask

  task automatic test_reset();
    iRes    = 1'b0;
    iComRaw = 16'($urandom);
    repeat (3) step();
    checks++;
    if (oCom !== 16'hFFFF) begin
      errors++; $display("FAIL rst_com: got %h expected ffff", oCom);
    end
    checks++;
    if (oChange !== 1'b0) begin
      errors++; $display("FAIL rst_change: got %b expected 0", oChange);
    end
    checks++;
    if (oTick !== 1'b0) begin
      errors++; $display("FAIL rst_tick: got %b expected 0", oTick);
    end
    iComRaw = 16'hFFFF;
    iRes    = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      checks++;
      if (oTick !== ((i % PRESC) == 0)) begin
        errors++;
        $display("FAIL tick_cycle%0d: got %b expected %b", i, oTick, (i % PRESC) == 0);
      end
    end
    checks++;
    if (oCom !== 16'hFFFF) begin
      errors++; $display("FAIL rst_com_after: got %h expected ffff", oCom);
    end
    $display("test_reset: oCom=%h after release", oCom);
  endtask

  // Common check of a single accepted change against the expected result.
  task automatic edge_case(input string name, input logic [15:0] base,
                           input logic [15:0] want);
    int first;
    int pulses;
    logic [15:0] fcom;
    logic fchg;
    measure(24, base, first, fcom, fchg, pulses);
    checks++;
    if (first < LAT_MIN || first > LAT_MAX) begin
      errors++; $display("FAIL %s_latency: got %0d expected %0d..%0d", name, first, LAT_MIN, LAT_MAX);
    end
    checks++;
    if (fcom !== want) begin
      errors++; $display("FAIL %s_com: got %h expected %h", name, fcom, want);
    end
    checks++;
    if (fchg !== 1'b1) begin
      errors++; $display("FAIL %s_change_edge: got %b expected 1", name, fchg);
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL %s_pulses: got %0d expected 1", name, pulses);
    end
    checks++;
    if (oCom !== want) begin
      errors++; $display("FAIL %s_final: got %h expected %h", name, oCom, want);
    end
    $display("%s: latency=%0d oCom=%h pulses=%0d", name, first, fcom, pulses);
  endtask

  task automatic test_activation();
    iComRaw[0] = 1'b0;
    edge_case("activation", 16'hFFFF, 16'hFFFE);
  endtask

  task automatic test_release();
    iComRaw[0] = 1'b1;
    edge_case("release", 16'hFFFE, 16'hFFFF);
  endtask

  task automatic test_glitch();
    int pulses;
    int moved;
    pulses = 0;
    moved  = 0;
    // Eight clocks low at the synchroniser output spans exactly two ticks.
    iComRaw[5] = 1'b0;
    for (int i = 1; i <= 28; i++) begin
      step();
      if (oChange === 1'b1) pulses++;
      if (oCom !== 16'hFFFF) moved++;
      if (i == 2 * PRESC) iComRaw[5] = 1'b1;
    end
    checks++;
    if (moved != 0) begin
      errors++; $display("FAIL glitch_com: got %0d changed clocks expected 0", moved);
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL glitch_pulses: got %0d expected 0", pulses);
    end
    $display("test_glitch: short pulse changed=%0d pulses=%0d", moved, pulses);
    iComRaw[5] = 1'b0;
    edge_case("glitch_long", 16'hFFFF, 16'hFFDF);
    iComRaw[5] = 1'b1;
    edge_case("glitch_restore", 16'hFFDF, 16'hFFFF);
  endtask

  task automatic test_simultaneous();
    iComRaw[3]  = 1'b0;
    iComRaw[12] = 1'b0;
    edge_case("simultaneous", 16'hFFFF, 16'hEFF7);
    iComRaw[3]  = 1'b1;
    iComRaw[12] = 1'b1;
    edge_case("simul_restore", 16'hEFF7, 16'hFFFF);
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    iComRaw[7] = 1'b0;
    // After 10 clocks two low ticks have been counted, the third not yet.
    repeat (10) step();
    checks++;
    if (oCom !== 16'hFFFF) begin
      errors++; $display("FAIL mid_before: got %h expected ffff", oCom);
    end
    iRes = 1'b0;
    #1;
    checks++;
    if (oCom !== 16'hFFFF || oChange !== 1'b0) begin
      errors++; $display("FAIL mid_async: got %h/%b expected ffff/0", oCom, oChange);
    end
    step();
    iRes = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      step();
      if (oChange === 1'b1) pulses++;
      if (i == 3 * PRESC - 1) begin
        checks++;
        if (oCom !== 16'hFFFF) begin
          errors++; $display("FAIL mid_hold: got %h expected ffff", oCom);
        end
      end
      if (i == 3 * PRESC) begin
        checks++;
        if (oCom !== 16'hFF7F) begin
          errors++; $display("FAIL mid_accept: got %h expected ff7f", oCom);
        end
        checks++;
        if (oChange !== 1'b1) begin
          errors++; $display("FAIL mid_change: got %b expected 1", oChange);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL mid_pulses: got %0d expected 1", pulses);
    end
    $display("test_reset_mid: oCom=%h pulses=%0d", oCom, pulses);
    iComRaw[7] = 1'b1;
    edge_case("mid_restore", 16'hFF7F, 16'hFFFF);
  endtask

  initial begin
    test_reset();
    test_activation();
    test_release();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_bsk_com_filter
